// File: rtl/sif_wr_buffer.sv
// sif_wr_buffer: queues single-cycle SIF write strobes in a FIFO and drains
// them in order to a memory/register target over a req/ack handshake.
module sif_wr_buffer #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wa_wr_s,
  input  logic [AW-1:0]                wa_addr,
  input  logic [DW-1:0]                wa_data_wr,
  output logic                         mem_req,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic                         mem_ack,
  output logic                         wa_full,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic                         ovf_clr,
  output logic                         ovf,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A push at full is only accepted when the head leaves on the same edge
  always_comb begin
    full       = (count == CW'(DEPTH));
    pop        = mem_req & mem_ack;
    push       = wa_wr_s & (~full | pop);
    drop       = wa_wr_s & ~push;
    rd_ptr_nxt = rd_ptr + PW'(1);
  end

  assign wa_full = full;
  assign level   = count;

  // Entry storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wa_addr;
      data_mem[wr_ptr] <= wa_data_wr;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: present the head, hold it until acked, chain without bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            mem_addr  <= addr_mem[rd_ptr];
            mem_wdata <= data_mem[rd_ptr];
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (count > CW'(1)) begin
              mem_addr  <= addr_mem[rd_ptr_nxt];
              mem_wdata <= data_mem[rd_ptr_nxt];
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Overflow status; a drop on the same edge as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      if (ovf_clr)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: doc/sif_wr_buffer.md
Name: sif_wr_buffer

Overview:
- Downstream consumer of the SIF write-side port (wa_wr_s / wa_addr / wa_data_wr).
- Captures every single-cycle write strobe into a FIFO, so no write is lost while the target is slow.
- Drains queued writes to a memory/register target over a req/ack handshake.
- Reports fill level and overflow status for the testbench monitors and for software.

Parameters:
- AW, 16, address width (matches wa_addr).
- DW, 16, data width (matches wa_data_wr).
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- wa_wr_s  input  1  write strobe; one write per high cycle.
- wa_addr  input  AW  write address, valid when wa_wr_s=1.
- wa_data_wr  input  DW  write data, valid when wa_wr_s=1.
- mem_req  output  1  request to target; held until acked.
- mem_addr  output  AW  address of head entry.
- mem_wdata  output  DW  data of head entry.
- mem_ack  input  1  target accepts current request on posedge where mem_req=1 and mem_ack=1.
- wa_full  output  1  count==DEPTH (combinational from count).
- level  output  $clog2(DEPTH+1)  current entry count.
- ovf_clr  input  1  clears ovf and drop_cnt.
- ovf  output  1  sticky: a write was dropped.
- drop_cnt  output  8  dropped writes; saturates at 255.

Behaviour:
Reset (rst_n=0, asynchronous):
- Pointers=0, count=0, FSM=IDLE.
- mem_req=0, mem_addr=0, mem_wdata=0, ovf=0, drop_cnt=0.
- level=0 and wa_full=0 follow from count.
- Reset during an outstanding request abandons it; all queued entries are discarded.

Push:
- At a posedge with wa_wr_s=1, {wa_addr, wa_data_wr} is written at wr_ptr if the FIFO is not full, or if it is full and a pop occurs on the same edge.
- A push at full with a same-edge pop is accepted; count is unchanged.
- Otherwise the write is dropped: ovf<=1, drop_cnt<=drop_cnt+1, saturating at 255.

Pop:
- Occurs at a posedge where mem_req=1 and mem_ack=1.
- Increments rd_ptr.
- Simultaneous push and pop leaves count unchanged.

Pointers:
- log2(DEPTH) bits, natural wrap-around.

Drain FSM, two states:
- IDLE: mem_req=0. If count>0 at a posedge, load mem_addr/mem_wdata from the head, set mem_req<=1, go to REQ.
- REQ: mem_req, mem_addr and mem_wdata held stable until ack.
- On ack with count>1 (pre-edge): load the next entry, keep mem_req=1, stay in REQ (back-to-back, no bubble).
- On ack with count==1: mem_req<=0, return to IDLE. A same-edge push into the emptying FIFO is presented from IDLE on the following edge.

mem_ack rules:
- mem_ack while mem_req=0 is ignored.

Latency:
- Write sampled into an empty FIFO at edge N gives mem_req=1 after edge N+1.

ovf_clr:
- Sets ovf<=0 and drop_cnt<=0.
- If a drop occurs on the same edge, the drop wins: ovf=1, drop_cnt=1.

Ordering:
- Strict FIFO order; no coalescing or reordering of same-address writes.

Test Plan:
1. Reset, then single write addr=0x0010 data=0xABCD with mem_ack tied 1 -> mem_req high exactly one cycle starting 2 edges after strobe, mem_addr=0x0010, mem_wdata=0xABCD, level returns to 0.
2. 8 back-to-back writes (addr 0..7, data 0x100+i) with mem_ack=0 -> level=8, wa_full=1. Then mem_ack=1 -> 8 consecutive ack cycles with no mem_req bubble, data emitted in order 0x100..0x107.
3. FIFO full with mem_ack=0, 3 more writes -> all dropped, ovf=1, drop_cnt=3, level stays 8. Assert ovf_clr -> ovf=0, drop_cnt=0.
4. FIFO full; write and mem_ack on the same edge -> write accepted, level stays 8, no drop, new entry emitted last.
5. 260 writes into a full FIFO with ack held low -> drop_cnt saturates at 255. ovf_clr coincident with a drop -> drop_cnt=1, ovf=1.
6. 5 entries queued, mem_req high; assert rst_n=0 mid-request -> mem_req, level and all outputs 0 immediately. After release, no stale request is issued.
